// File: rtl/arm_shifter_pipe.sv
// rtl/arm_shifter_pipe.sv - two-stage pipelined ARM-semantics barrel shifter
//
// Purpose:
//   LSL/LSR/ASR/ROR/RRX with ARM shifter carry-out, register amounts 0..255 and
//   immediate #0 special cases. Stage 1 registers the operand together with a
//   decoded amount class; stage 2 runs a log2 mux shifter and registers the
//   result. Valid/ready on both sides; at most two operands in flight.
//
// Optional feature macro: SHIFTER_FLAGS_EN (adds out_zero / out_neg).
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake
//   in_data [WIDTH]     operand
//   in_amt  [8]         shift amount (immediate mode uses [LOG2W-1:0])
//   in_op   [2]         00 LSL, 01 LSR, 10 ASR, 11 ROR
//   in_imm              1 = immediate encoding
//   in_carry            current C flag
//   out_valid/out_ready result handshake
//   out_data [WIDTH]    shifted result
//   out_carry           shifter carry-out
//   out_zero, out_neg   (SHIFTER_FLAGS_EN only) result==0, result msb

module arm_shifter_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [7:0]       in_amt,
  input  logic [1:0]       in_op,
  input  logic             in_imm,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry
`ifdef SHIFTER_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_neg
`endif
);

  localparam int         LOG2W = $clog2(WIDTH);
  localparam logic [7:0] W8    = 8'(WIDTH);

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  // Amount class: everything stage 2 needs besides the low amount bits.
  //   PASS  : result = data, carry = cin
  //   SHIFT : real shift/rotate by s1_amt (1..W-1)
  //   FULL  : LSL/LSR by exactly W, ASR by >= W, ROR by nonzero multiple of W
  //   OVER  : LSL/LSR by more than W -> zero, carry 0
  //   RRX   : immediate ROR #0
  typedef enum logic [2:0] {
    CLS_PASS,
    CLS_SHIFT,
    CLS_FULL,
    CLS_OVER,
    CLS_RRX
  } cls_t;

  // ---------------------------------------------------------------- stage 1
  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic [1:0]       s1_op;
  logic             s1_cin;
  logic [LOG2W-1:0] s1_amt;
  cls_t             s1_cls;

  logic             s2_take;
  logic [LOG2W-1:0] amt_lo;
  logic             amt_hi_zero;
  cls_t             d_cls;

  assign amt_lo      = in_amt[LOG2W-1:0];
  assign amt_hi_zero = (in_amt[7:LOG2W] == '0);

  // Stage 2 can take stage 1 when it is empty or its result drains now.
  assign s2_take  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_take;

  always_comb begin
    d_cls = CLS_PASS;
    if (in_imm) begin
      if (amt_lo == '0) begin
        case (in_op)
          OP_LSL:  d_cls = CLS_PASS;
          OP_LSR:  d_cls = CLS_FULL;
          OP_ASR:  d_cls = CLS_FULL;
          default: d_cls = CLS_RRX;
        endcase
      end else begin
        d_cls = CLS_SHIFT;
      end
    end else if (in_amt == 8'd0) begin
      d_cls = CLS_PASS;
    end else if (in_op == OP_ROR) begin
      // Rotation only cares about n mod W.
      d_cls = (amt_lo == '0) ? CLS_FULL : CLS_SHIFT;
    end else if (amt_hi_zero) begin
      d_cls = CLS_SHIFT;
    end else if (in_amt == W8) begin
      d_cls = CLS_FULL;
    end else begin
      d_cls = (in_op == OP_ASR) ? CLS_FULL : CLS_OVER;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_op    <= OP_LSL;
      s1_cin   <= 1'b0;
      s1_amt   <= '0;
      s1_cls   <= CLS_PASS;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_op   <= in_op;
        s1_cin  <= in_carry;
        s1_amt  <= amt_lo;
        s1_cls  <= d_cls;
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  // Left and right shifts run on W+1 bit vectors so the last bit shifted out
  // lands in the extra bit and becomes the carry without a separate mux.
  logic [WIDTH:0]   l_v;
  logic [WIDTH:0]   r_v;
  logic [WIDTH-1:0] rot;
  logic [WIDTH-1:0] sh_data;
  logic             sh_carry;

  always_comb begin
    l_v = {1'b0, s1_data};
    r_v = {s1_data, 1'b0};
    rot = s1_data;
    for (int i = 0; i < LOG2W; i++) begin
      if (s1_amt[i]) begin
        l_v = l_v << (1 << i);
        if (s1_op == OP_ASR) begin
          r_v = $signed(r_v) >>> (1 << i);
        end else begin
          r_v = r_v >> (1 << i);
        end
        rot = (rot >> (1 << i)) | (rot << (WIDTH - (1 << i)));
      end
    end

    sh_data  = s1_data;
    sh_carry = s1_cin;
    case (s1_cls)
      CLS_SHIFT: begin
        case (s1_op)
          OP_LSL: begin
            sh_data  = l_v[WIDTH-1:0];
            sh_carry = l_v[WIDTH];
          end
          OP_ROR: begin
            sh_data  = rot;
            sh_carry = rot[WIDTH-1];
          end
          default: begin
            sh_data  = r_v[WIDTH:1];
            sh_carry = r_v[0];
          end
        endcase
      end
      CLS_FULL: begin
        case (s1_op)
          OP_LSL: begin
            sh_data  = '0;
            sh_carry = s1_data[0];
          end
          OP_LSR: begin
            sh_data  = '0;
            sh_carry = s1_data[WIDTH-1];
          end
          OP_ASR: begin
            sh_data  = {WIDTH{s1_data[WIDTH-1]}};
            sh_carry = s1_data[WIDTH-1];
          end
          default: begin
            sh_data  = s1_data;
            sh_carry = s1_data[WIDTH-1];
          end
        endcase
      end
      CLS_OVER: begin
        sh_data  = '0;
        sh_carry = 1'b0;
      end
      CLS_RRX: begin
        sh_data  = {s1_cin, s1_data[WIDTH-1:1]};
        sh_carry = s1_data[0];
      end
      default: begin
        sh_data  = s1_data;
        sh_carry = s1_cin;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_carry <= 1'b0;
`ifdef SHIFTER_FLAGS_EN
      out_zero  <= 1'b0;
      out_neg   <= 1'b0;
`endif
    end else if (s2_take) begin
      out_valid <= s1_valid;
      // Result registers only change when a new operand arrives, so a
      // stalled result stays put.
      if (s1_valid) begin
        out_data  <= sh_data;
        out_carry <= sh_carry;
`ifdef SHIFTER_FLAGS_EN
        out_zero  <= (sh_data == '0);
        out_neg   <= sh_data[WIDTH-1];
`endif
      end
    end
  end

endmodule

// File: doc/arm_shifter_pipe.md
Name: arm_shifter_pipe

Overview:
- Parametrised, two-stage pipelined ARM-semantics shifter for the ARM7TDMI datapath.
- Operations: LSL, LSR, ASR, ROR and RRX, with shifter carry-out and full ARM amount rules (register amounts 0..255, immediate-encoding #0 special cases).
- Sits between register-read and the ALU operand-2 path.
- Uses valid/ready handshakes on both sides, so the decode stage and the ALU can stall independently.

Parameters:
- WIDTH, 32, data width; power of two, 8..64. Local LOG2W = log2(WIDTH).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input operand valid.
- in_ready  out  1  shifter can accept an operand this cycle.
- in_data  in  WIDTH  operand to shift.
- in_amt  in  8  shift amount; register mode uses all 8 bits, immediate mode uses in_amt[LOG2W-1:0].
- in_op  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
- in_imm  in  1  1 = immediate encoding (#0 special cases), 0 = register amount.
- in_carry  in  1  current C flag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  shifted result.
- out_carry  out  1  shifter carry-out.

Behaviour:
- Reset (async, immediate): stage valids cleared; out_valid=0, out_data=0, out_carry=0; in_ready=1 after release. All in-flight operands are discarded; nothing emerges after reset.
- Transfers occur on a rising edge when valid&&ready on that interface.
- Stage 1 registers the operand, op, carry and a decoded effective amount/special-case class.
- Stage 2 runs a log2 mux shifter on the stage-1 registers and registers out_data/out_carry.
- Latency: result valid 2 cycles after acceptance. Throughput is 1 per cycle when out_ready=1.
- Stage advance: a stage loads when it is empty or its contents move on this cycle. in_ready = !s1_valid || s2 can take s1. No combinational in_valid->out_valid path.
- While out_valid && !out_ready, out_data/out_carry are held stable. At most 2 operands are held. Order is preserved; no drop or duplicate.
- Register mode (n = in_amt, W = WIDTH):
  - LSL: n=0 -> data, c=cin; 1..W-1 -> data<<n, c=data[W-n]; n=W -> 0, c=data[0]; n>W -> 0, c=0.
  - LSR: n=0 -> data, cin; 1..W-1 -> data>>n, c=data[n-1]; n=W -> 0, c=data[W-1]; n>W -> 0, c=0.
  - ASR: n=0 -> data, cin; 1..W-1 -> arithmetic shift, c=data[n-1]; n>=W -> all bits = data[W-1], c=data[W-1].
  - ROR: n=0 -> data, cin; n nonzero with n mod W = 0 -> data, c=data[W-1]; otherwise rotate right by n mod W, c=result[W-1].
- Immediate mode (k = in_amt[LOG2W-1:0]; upper bits ignored):
  - LSL #0 -> data, cin.
  - LSR #0 -> behaves as LSR W.
  - ASR #0 -> behaves as ASR W.
  - ROR #0 -> RRX: {cin, data[W-1:1]}, c=data[0].
  - k != 0 -> same as register mode with n = k.
- Simultaneous input accept and output drain in one cycle is legal and sustains full rate.

Optional Feature:
- Macro SHIFTER_FLAGS_EN.
- Defined: adds outputs out_zero (1 bit, out_data==0) and out_neg (1 bit, out_data[WIDTH-1]). Both are registered in stage 2 alongside out_data, follow the same hold rules, and reset to 0.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- WIDTH=32, register LSL n=4, data 0xF000000F, cin=0 -> out_data 0x000000F0, out_carry=1, out_valid 2 cycles after accept.
- Immediate ROR #0 (RRX), data 0x00000003, cin=1 -> 0x80000001, c=1. Immediate LSR #0, data 0x80000000 -> 0x00000000, c=1.
- Register ASR n=200, data 0x80000001 -> 0xFFFFFFFF, c=1. Register ROR n=64, data 0x80000001, cin=0 -> 0x80000001, c=1. Register LSL n=33 -> 0, c=0. Register LSR n=32, data 0x80000000 -> 0, c=1.
- Backpressure: 4 back-to-back operands, out_ready held low 3 cycles after first out_valid -> in_ready low once 2 are held, output stable while stalled, all 4 results in order with no loss or duplication.
- Full throughput: 16 random operands with out_ready=1 -> one result per cycle, all matching a reference model.
- rst pulsed mid-stream with 2 operands in flight -> out_valid=0 and out_data=0 immediately (asynchronous); no stale result after release; in_ready=1 on the first cycle after release.
